reg_writeback: RTL and testbench



---
 rtl/reg_bank_pkg.sv | 16 +
 rtl/wb_fifo.sv | 57 +++++
 rtl/reg_writeback.sv | 114 +++++++++++
 tb/tb_reg_writeback.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared widths and the write-back queue entry type for the
// register datapath.
package reg_bank_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned NUM_REGS = 8;

  // One queued write-back: destination (R or general register) plus value.
  typedef struct packed {
    logic              toR;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry in-order FIFO of wb_entry_t.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, din   - write din at tail (caller guarantees not full)
//   pop, dout   - dout is the head entry; pop removes it (caller guarantees not empty)
//   count       - number of stored entries, 0..DEPTH
// Full/empty come from count; pointers wrap naturally since DEPTH is a power of two.
module wb_fifo
  import reg_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              din,
  input  logic                   pop,
  output wb_entry_t              dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: queues write-back requests and commits them in order into
// eight general registers and R, one per non-held cycle.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   wr_valid/wr_ready                - request handshake (ready = queue not full)
//   wr_sel, wr_toR, wr_data          - destination and value
//   hold                             - suppress commit this cycle
//   reg0..reg7, regR                 - committed register values
//   pending, idle                    - queue occupancy, occupancy == 0
// Build option: define REG0_ZERO_EN to hard-wire reg0 to zero; commits to
// register 0 then still pop the queue but write nothing.
module reg_writeback #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [2:0]             wr_sel,
  input  logic                   wr_toR,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   hold,
  output logic [DATA_W-1:0]      reg0,
  output logic [DATA_W-1:0]      reg1,
  output logic [DATA_W-1:0]      reg2,
  output logic [DATA_W-1:0]      reg3,
  output logic [DATA_W-1:0]      reg4,
  output logic [DATA_W-1:0]      reg5,
  output logic [DATA_W-1:0]      reg6,
  output logic [DATA_W-1:0]      reg7,
  output logic [DATA_W-1:0]      regR,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   idle
);

  import reg_bank_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = reg_bank_pkg::DATA_W;

  logic             push;
  logic             commit;
  logic [CNT_W-1:0] count;
  wb_entry_t        wr_entry;
  wb_entry_t        head;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] reg_r;

  // Ready and commit depend only on registered occupancy and hold.
  assign wr_ready = (count != CNT_W'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign commit   = !hold && (count != '0);

  always_comb begin
    wr_entry      = '0;
    wr_entry.toR  = wr_toR;
    wr_entry.sel  = SEL_W'(wr_sel);
    wr_entry.data = ENT_W'(wr_data);
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_entry),
    .pop   (commit),
    .dout  (head),
    .count (count)
  );

  // Commit head entry into the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      reg_r <= '0;
    end else if (commit) begin
      if (head.toR) begin
        reg_r <= DATA_W'(head.data);
      end
`ifdef REG0_ZERO_EN
      else if (head.sel != '0) begin
        regs[head.sel] <= DATA_W'(head.data);
      end
`else
      else begin
        regs[head.sel] <= DATA_W'(head.data);
      end
`endif
    end
  end

`ifdef REG0_ZERO_EN
  assign reg0 = '0;
`else
  assign reg0 = regs[0];
`endif
  assign reg1    = regs[1];
  assign reg2    = regs[2];
  assign reg3    = regs[3];
  assign reg4    = regs[4];
  assign reg5    = regs[5];
  assign reg6    = regs[6];
  assign reg7    = regs[7];
  assign regR    = reg_r;
  assign pending = count;
  assign idle    = (count == '0);

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed vectors with hand-computed expectations for
// reg_writeback (default DEPTH=2, DATA_W=16).
module tb_reg_writeback;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_sel;
  logic        wr_toR;
  logic [15:0] wr_data;
  logic        hold;
  logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7, regR;
  logic [1:0]  pending;
  logic        idle;
  logic [15:0] r [8];

  int checks   = 0;
  int failures = 0;

  reg_writeback #(.DEPTH(2), .DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_toR   (wr_toR),
    .wr_data  (wr_data),
    .hold     (hold),
    .reg0     (reg0),
    .reg1     (reg1),
    .reg2     (reg2),
    .reg3     (reg3),
    .reg4     (reg4),
    .reg5     (reg5),
    .reg6     (reg6),
    .reg7     (reg7),
    .regR     (regR),
    .pending  (pending),
    .idle     (idle)
  );

  assign r[0] = reg0;
  assign r[1] = reg1;
  assign r[2] = reg2;
  assign r[3] = reg3;
  assign r[4] = reg4;
  assign r[5] = reg5;
  assign r[6] = reg6;
  assign r[7] = reg7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_reg%0d", tag, i), 32'(r[i]), 32'h0);
    check({tag, "_regR"}, 32'(regR), 32'h0);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    check({tag, "_idle"}, 32'(idle), 32'd1);
    check({tag, "_ready"}, 32'(wr_ready), 32'd1);
  endtask

  // Safety bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_sel = 3'd0; wr_toR = 1'b0;
    wr_data = 16'h0; hold = 1'b0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Single write, one-cycle commit latency, no fall-through.
    wr_valid = 1'b1; wr_sel = 3'd3; wr_data = 16'hBEEF;
    step();
    wr_valid = 1'b0;
    check("single_nofall_reg3", 32'(reg3), 32'h0);
    check("single_pending1", 32'(pending), 32'd1);
    check("single_idle0", 32'(idle), 32'd0);
    step();
    check("single_reg3", 32'(reg3), 32'hBEEF);
    check("single_reg2", 32'(reg2), 32'h0);
    check("single_regR", 32'(regR), 32'h0);
    check("single_idle", 32'(idle), 32'd1);

    // Hold backpressure fills the queue.
    hold = 1'b1;
    wr_valid = 1'b1; wr_toR = 1'b1; wr_sel = 3'd0; wr_data = 16'h0011;
    step();
    wr_toR = 1'b0; wr_sel = 3'd5; wr_data = 16'h0022;
    step();
    wr_valid = 1'b0;
    check("hold_pending2", 32'(pending), 32'd2);
    check("hold_ready0", 32'(wr_ready), 32'd0);
    check("hold_regR", 32'(regR), 32'h0);
    check("hold_reg5", 32'(reg5), 32'h0);
    step();
    check("hold_still_regR", 32'(regR), 32'h0);
    check("hold_still_pending", 32'(pending), 32'd2);
    hold = 1'b0;
    step();
    check("rel1_regR", 32'(regR), 32'h0011);
    check("rel1_reg5", 32'(reg5), 32'h0);
    check("rel1_ready", 32'(wr_ready), 32'd1);
    check("rel1_pending", 32'(pending), 32'd1);
    step();
    check("rel2_reg5", 32'(reg5), 32'h0022);
    check("rel2_idle", 32'(idle), 32'd1);

    // Same-destination ordering.
    wr_valid = 1'b1; wr_sel = 3'd1; wr_data = 16'h1111;
    step();
    wr_data = 16'h2222;
    step();
    wr_valid = 1'b0;
    check("order_first", 32'(reg1), 32'h1111);
    step();
    check("order_second", 32'(reg1), 32'h2222);
    check("order_idle", 32'(idle), 32'd1);

    // Streaming writes: push and pop every cycle.
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_sel  = 3'(i);
      wr_data = 16'(i << 4);
      step();
      check($sformatf("stream_ready%0d", i), 32'(wr_ready), 32'd1);
      check($sformatf("stream_pend%0d", i), 32'(pending), 32'd1);
      if (i > 0) check($sformatf("stream_land%0d", i - 1), 32'(r[i-1]), 32'((i - 1) << 4));
    end
    wr_valid = 1'b0;
    step();
    check("stream_land7", 32'(reg7), 32'h0070);
    check("stream_reg3", 32'(reg3), 32'h0030);
    check("stream_idle", 32'(idle), 32'd1);

    // Reset mid-drain discards queued writes.
    hold = 1'b1;
    wr_valid = 1'b1; wr_sel = 3'd2; wr_data = 16'hAAAA;
    step();
    wr_sel = 3'd4; wr_data = 16'h5555;
    step();
    wr_valid = 1'b0;
    check("mid_pending2", 32'(pending), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    #3;
    rst_n = 1'b1;
    hold = 1'b0;
    step();
    step();
    check("post_reg2", 32'(reg2), 32'h0);
    check("post_reg4", 32'(reg4), 32'h0);
    check("post_idle", 32'(idle), 32'd1);

    // Register 0 write.
    wr_valid = 1'b1; wr_sel = 3'd0; wr_data = 16'hFFFF;
    step();
    wr_valid = 1'b0;
    check("r0_pending1", 32'(pending), 32'd1);
    step();
    check("r0_pending0", 32'(pending), 32'd0);
`ifdef REG0_ZERO_EN
    check("r0_zero", 32'(reg0), 32'h0);
`else
    check("r0_write", 32'(reg0), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
